bram_port_arbiter: RTL and testbench
====================================

// Module: bram_port_arbiter
// PURPOSE
//  Shares one port of a dual-port block RAM (port B of the loaded/initialised BRAM) between two
//  requesters, e.g. CPU data bus and DMA engine. Each requester gets a valid/ready request channel
//  and a fixed-latency read response. Supports locked bursts, with a starvation guard.
// PARAMETERS
//  ADDR_WIDTH  10  BRAM address width
//  DATA_WIDTH  32  BRAM data width
//  RD_LATENCY  1   BRAM read latency: 1 = BRAM PIPELINED=0, 2 = PIPELINED=1; other values illegal
//  LOCK_MAX    16  max cycles a lock may hold ownership; 0 = unlimited
// PORTS
//  CLK           in   1           clock, all logic on posedge
//  RST_N         in   1           asynchronous active-low reset
//  REQn_VALID    in   1           n=0,1: request present
//  REQn_READY    out  1           request accepted this cycle (VALID&READY = beat)
//  REQn_WE       in   1           1 = write, 0 = read
//  REQn_LOCK     in   1           keep ownership after this beat
//  REQn_ADDR     in   ADDR_WIDTH  address
//  REQn_WDATA    in   DATA_WIDTH  write data
//  RSPn_VALID    out  1           read data valid for requester n (no backpressure)
//  RSPn_RDATA    out  DATA_WIDTH  read data
//  BRAM_EN       out  1           to BRAM ENB
//  BRAM_WE       out  1           to BRAM WEB
//  BRAM_ADDR     out  ADDR_WIDTH  to BRAM ADDRB
//  BRAM_DI       out  DATA_WIDTH  to BRAM DIB
//  BRAM_DO       in   DATA_WIDTH  from BRAM DOB
// BEHAVIOUR
//  - Reset (RST_N low, async): state=IDLE, prio=0, lock counter=0, tag pipe cleared;
//    REQn_READY=0, RSPn_VALID=0, RSPn_RDATA=0, BRAM_EN=0, BRAM_WE=0 while reset asserted.
//  - FSM states: IDLE, OWN0, OWN1. Grant is combinational from state and VALIDs:
//    IDLE: grant to valid requester; both valid -> requester prio. OWNn: grant only n.
//  - REQn_READY = grant==n & REQn_VALID. At most one READY per cycle. BRAM_EN = any beat;
//    BRAM_WE/ADDR/DI muxed from granted requester; when no beat, BRAM_EN=0, BRAM_WE=0.
//  - Transitions on beat by n: LOCK=1 -> OWNn; LOCK=0 -> IDLE. No beat -> hold state.
//  - In OWNn requester n may idle (VALID=0); other requester stays blocked.
//  - Lock counter: cleared on entry to OWNn, +1 each cycle in OWNn. LOCK_MAX>0 and counter
//    reaches LOCK_MAX-1 -> next state IDLE regardless of LOCK, and prio set to other requester.
//  - Writes: no response; beat = completion. BRAM write-first echo on BRAM_DO ignored.
//  - Reads: beat pushes {valid,id} into RD_LATENCY-deep tag shift register. RSPid_VALID=1 and
//    RSPid_RDATA=BRAM_DO exactly RD_LATENCY cycles after beat. Back-to-back reads from either
//    requester fully pipelined, one per cycle, responses in issue order. RDATA holds last value
//    when VALID=0.
//  - Read after write, same address, consecutive beats: read returns new data.
//  - Reset mid-operation: in-flight tags discarded; no RSP after reset release for pre-reset beats.
// CONFIGURATION
//  BRAM_ARB_RR_EN defined: prio toggles to the other requester after every beat that returns
//   the FSM to IDLE (incl. forced lock release) -> round-robin fairness.
//  BRAM_ARB_RR_EN undefined: fixed priority, requester 0 wins in IDLE; forced lock release
//   still gives requester 1 one grant (prio=1 until its next beat, then back to 0).
// TESTING
//  1. Reset release, REQ0 read addr 0x004 (BRAM holds 0xDEADBEEF), RD_LATENCY=1 -> READY0 same
//     cycle, RSP0_VALID one cycle later with 0xDEADBEEF; RSP1_VALID stays 0.
//  2. Both VALID reads every cycle, addrs 0x10/0x20, RR_EN defined -> grants alternate 0,1,0,1;
//     RSPs alternate, each RD_LATENCY=2 cycles after its beat, correct data.
//  3. REQ0 writes 0x0000_1234 to 0x008, next cycle REQ1 reads 0x008 -> RSP1 returns 0x0000_1234.
//  4. REQ0 burst of 4 reads with LOCK=1 on first 3, REQ1 VALID throughout -> READY1 low until
//     4th REQ0 beat, then REQ1 granted next cycle.
//  5. LOCK_MAX=4, REQ0 holds LOCK=1 forever, REQ1 VALID -> ownership forced to IDLE after 4 cycles,
//     REQ1 granted once, both RR_EN defined and undefined.
//  6. Assert RST_N with 2 reads in flight (RD_LATENCY=2) -> RSPn_VALID=0 immediately, and
//     stays 0 after release.

Source files
------------

// File: rtl/bram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : bram_port_arbiter_if
// Brief    : Request/response channels of two requesters plus the shared
//            BRAM port-B signals, as seen by the arbiter (slave) and by the
//            requesters/BRAM (master).
// Revision : 1.0 - initial release
// ============================================================================
interface bram_port_arbiter_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    // Index n of each vector belongs to requester n
    logic [1:0]                 req_valid;
    logic [1:0]                 req_ready;
    logic [1:0]                 req_we;
    logic [1:0]                 req_lock;
    logic [1:0][ADDR_WIDTH-1:0] req_addr;
    logic [1:0][DATA_WIDTH-1:0] req_wdata;
    logic [1:0]                 rsp_valid;
    logic [1:0][DATA_WIDTH-1:0] rsp_rdata;

    logic                       bram_en;
    logic                       bram_we;
    logic [ADDR_WIDTH-1:0]      bram_addr;
    logic [DATA_WIDTH-1:0]      bram_di;
    logic [DATA_WIDTH-1:0]      bram_do;

    modport slave (
        input  req_valid, req_we, req_lock, req_addr, req_wdata, bram_do,
        output req_ready, rsp_valid, rsp_rdata, bram_en, bram_we, bram_addr, bram_di
    );

    modport master (
        output req_valid, req_we, req_lock, req_addr, req_wdata, bram_do,
        input  req_ready, rsp_valid, rsp_rdata, bram_en, bram_we, bram_addr, bram_di
    );
endinterface
`default_nettype wire

// File: rtl/bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bram_port_arbiter
// Brief    : Shares BRAM port B between two requesters with locked bursts,
//            a lock-length starvation guard and fixed-latency read responses.
//            Define BRAM_ARB_RR_EN for round-robin priority; otherwise
//            requester 0 has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module bram_port_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1,   // 1 or 2
    parameter int LOCK_MAX   = 16   // 0 = unlimited lock
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    bram_port_arbiter_if.slave  bus
);

    localparam int                 c_CNT_W     = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
    localparam bit                 c_LOCK_EN   = (LOCK_MAX > 0);
    localparam logic [c_CNT_W-1:0] c_LOCK_LAST = c_CNT_W'((LOCK_MAX > 0) ? LOCK_MAX - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_prio;
    logic                  w_prio_nxt;
    logic [c_CNT_W-1:0]    r_lock_cnt;
    logic [c_CNT_W-1:0]    w_lock_cnt_nxt;
    logic                  w_gnt_vld;
    logic                  w_gnt_id;
    logic                  w_force;
    logic                  w_owner;

    logic [RD_LATENCY-1:0] r_tag_vld;
    logic [RD_LATENCY-1:0] r_tag_id;
    logic [1:0]            w_rsp_valid;
    logic [1:0][DATA_WIDTH-1:0] r_rdata_hold;

    // Grant is suppressed while reset is asserted so no beat leaks out
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_id  = 1'b0;
        if (rst_n) begin
            case (r_state)
                ST_IDLE: begin
                    if (&bus.req_valid) begin
                        w_gnt_vld = 1'b1;
                        w_gnt_id  = r_prio;
                    end else if (bus.req_valid[0]) begin
                        w_gnt_vld = 1'b1;
                        w_gnt_id  = 1'b0;
                    end else if (bus.req_valid[1]) begin
                        w_gnt_vld = 1'b1;
                        w_gnt_id  = 1'b1;
                    end
                end
                ST_OWN0: begin
                    w_gnt_vld = bus.req_valid[0];
                    w_gnt_id  = 1'b0;
                end
                ST_OWN1: begin
                    w_gnt_vld = bus.req_valid[1];
                    w_gnt_id  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_prio_nxt     = r_prio;
        w_lock_cnt_nxt = '0;
        w_owner        = (r_state == ST_OWN1);
        w_force        = c_LOCK_EN && (r_state != ST_IDLE) && (r_lock_cnt == c_LOCK_LAST);

        if (w_gnt_vld) begin
            if (bus.req_lock[w_gnt_id])
                w_state_nxt = w_gnt_id ? ST_OWN1 : ST_OWN0;
            else
                w_state_nxt = ST_IDLE;
        end
        if (w_force)
            w_state_nxt = ST_IDLE;

        if (w_force)
            w_prio_nxt = ~w_owner;
`ifdef BRAM_ARB_RR_EN
        else if (w_gnt_vld && (w_state_nxt == ST_IDLE))
            w_prio_nxt = ~w_gnt_id;
`else
        // A forced release handed priority to requester 1 for one grant only
        else if (w_gnt_vld && w_gnt_id)
            w_prio_nxt = 1'b0;
`endif

        if (c_LOCK_EN && (r_state != ST_IDLE) && (w_state_nxt == r_state))
            w_lock_cnt_nxt = r_lock_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_prio     <= 1'b0;
            r_lock_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_prio     <= w_prio_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
        end
    end

    always_comb begin
        bus.req_ready = w_gnt_vld ? (2'b01 << w_gnt_id) : 2'b00;
        bus.bram_en   = w_gnt_vld;
        bus.bram_we   = w_gnt_vld & bus.req_we[w_gnt_id];
        bus.bram_addr = bus.req_addr[w_gnt_id];
        bus.bram_di   = bus.req_wdata[w_gnt_id];
    end

    // Read tags travel alongside the BRAM read pipeline; writes carry no tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_vld <= '0;
            r_tag_id  <= '0;
        end else begin
            r_tag_vld[0] <= w_gnt_vld & ~bus.req_we[w_gnt_id];
            r_tag_id[0]  <= w_gnt_id;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_id[i]  <= r_tag_id[i-1];
            end
        end
    end

    always_comb begin
        for (int n = 0; n < 2; n++) begin
            w_rsp_valid[n]   = r_tag_vld[RD_LATENCY-1] && (r_tag_id[RD_LATENCY-1] == 1'(n));
            bus.rsp_rdata[n] = w_rsp_valid[n] ? bus.bram_do : r_rdata_hold[n];
        end
        bus.rsp_valid = w_rsp_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata_hold <= '0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (w_rsp_valid[n])
                    r_rdata_hold[n] <= bus.bram_do;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_port_arbiter
// Brief    : Drives two arbiters (read latency 1 and 2, LOCK_MAX 4) with the
//            same directed vectors; a scoreboard checks read responses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bram_port_arbiter;

`ifdef BRAM_ARB_RR_EN
    localparam bit c_RR = 1'b1;
`else
    localparam bit c_RR = 1'b0;
`endif

    typedef struct {
        int          due;
        bit          req;
        logic [31:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    int              cyc = 0;
    int              n_chk = 0;
    int              n_fail = 0;

    logic [1:0]       s_valid, s_we, s_lock;
    logic [1:0][9:0]  s_addr;
    logic [1:0][31:0] s_wdata;

    exp_t        q_a[$];
    exp_t        q_b[$];
    logic [31:0] last_a [2];
    logic [31:0] last_b [2];

    logic [31:0] mem_a [1024];
    logic [31:0] mem_b [1024];
    logic [31:0] do_a, do_b1, do_b2;

    bram_port_arbiter_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) ifa ();
    bram_port_arbiter_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) ifb ();

    assign ifa.req_valid = s_valid;
    assign ifa.req_we    = s_we;
    assign ifa.req_lock  = s_lock;
    assign ifa.req_addr  = s_addr;
    assign ifa.req_wdata = s_wdata;
    assign ifa.bram_do   = do_a;
    assign ifb.req_valid = s_valid;
    assign ifb.req_we    = s_we;
    assign ifb.req_lock  = s_lock;
    assign ifb.req_addr  = s_addr;
    assign ifb.req_wdata = s_wdata;
    assign ifb.bram_do   = do_b2;

    bram_port_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .RD_LATENCY(1), .LOCK_MAX(4)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave)
    );

    bram_port_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .RD_LATENCY(2), .LOCK_MAX(4)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write-first BRAM models: PIPELINED=0 for dut_a, PIPELINED=1 for dut_b
    always @(posedge clk) begin
        if (ifa.bram_en) begin
            if (ifa.bram_we) begin
                mem_a[ifa.bram_addr] = ifa.bram_di;
                do_a <= ifa.bram_di;
            end else begin
                do_a <= mem_a[ifa.bram_addr];
            end
        end
        if (ifb.bram_en) begin
            if (ifb.bram_we) begin
                mem_b[ifb.bram_addr] = ifb.bram_di;
                do_b1 <= ifb.bram_di;
            end else begin
                do_b1 <= mem_b[ifb.bram_addr];
            end
        end
        do_b2 <= do_b1;
    end

    task automatic mon(input int k, input logic [1:0] vld, input logic [1:0][31:0] rd);
        exp_t       e;
        bit         have = 1'b0;
        logic [1:0] ev;
        logic [31:0] want;
        if (k == 0) begin
            if (q_a.size() > 0 && q_a[0].due == cyc) begin
                e = q_a.pop_front();
                have = 1'b1;
            end
        end else begin
            if (q_b.size() > 0 && q_b[0].due == cyc) begin
                e = q_b.pop_front();
                have = 1'b1;
            end
        end
        ev = have ? (e.req ? 2'b10 : 2'b01) : 2'b00;
        n_chk++;
        if (vld !== ev) begin
            n_fail++;
            $display("FAIL rsp_valid dut%0d cyc %0d: got %b want %b", k, cyc, vld, ev);
        end
        for (int r = 0; r < 2; r++) begin
            want = ev[r] ? e.data : ((k == 0) ? last_a[r] : last_b[r]);
            n_chk++;
            if (rd[r] !== want) begin
                n_fail++;
                $display("FAIL rsp_rdata%0d dut%0d cyc %0d: got %h want %h", r, k, cyc, rd[r], want);
            end
            if (ev[r]) begin
                if (k == 0) last_a[r] = e.data;
                else        last_b[r] = e.data;
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, ifa.rsp_valid, ifa.rsp_rdata);
        mon(1, ifb.rsp_valid, ifb.rsp_rdata);
    end

    task automatic chk_port(input int k, input logic [1:0] rdy, input logic en, input logic we,
                            input logic [9:0] addr, input logic [1:0] xr, input logic xwe,
                            input logic [9:0] xa);
        n_chk++;
        if (rdy !== xr) begin
            n_fail++;
            $display("FAIL req_ready dut%0d cyc %0d: got %b want %b", k, cyc, rdy, xr);
        end
        n_chk++;
        if ({en, we} !== {|xr, xwe}) begin
            n_fail++;
            $display("FAIL bram_en_we dut%0d cyc %0d: got %b want %b", k, cyc, {en, we}, {|xr, xwe});
        end
        if (|xr) begin
            n_chk++;
            if (addr !== xa) begin
                n_fail++;
                $display("FAIL bram_addr dut%0d cyc %0d: got %h want %h", k, cyc, addr, xa);
            end
        end
    endtask

    // One cycle of stimulus: xr is the expected grant, xd the expected read data
    task automatic drive(input logic [1:0] v, input logic [1:0] we, input logic [1:0] lk,
                         input logic [9:0] a0, input logic [9:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic [1:0] xr, input logic [31:0] xd);
        logic       gid;
        logic       xwe;
        logic [9:0] xa;
        exp_t       e;
        @(posedge clk);
        #1;
        s_valid = v; s_we = we; s_lock = lk;
        s_addr[0] = a0; s_addr[1] = a1;
        s_wdata[0] = d0; s_wdata[1] = d1;
        @(negedge clk);
        gid = xr[1];
        xwe = (|xr) & we[gid];
        xa  = gid ? a1 : a0;
        chk_port(0, ifa.req_ready, ifa.bram_en, ifa.bram_we, ifa.bram_addr, xr, xwe, xa);
        chk_port(1, ifb.req_ready, ifb.bram_en, ifb.bram_we, ifb.bram_addr, xr, xwe, xa);
        if ((|xr) && !xwe) begin
            e.req = gid; e.data = xd;
            e.due = cyc + 1; q_a.push_back(e);
            e.due = cyc + 2; q_b.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(2'b00, 2'b00, 2'b00, 10'h0, 10'h0, 32'h0, 32'h0, 2'b00, 32'h0);
    endtask

    task automatic clear_sb();
        q_a.delete();
        q_b.delete();
        for (int r = 0; r < 2; r++) begin
            last_a[r] = 32'h0;
            last_b[r] = 32'h0;
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = 32'hC0DE_0000 | 32'(i);
            mem_b[i] = 32'hC0DE_0000 | 32'(i);
        end
        mem_a[4] = 32'hDEAD_BEEF;
        mem_b[4] = 32'hDEAD_BEEF;
        s_valid = '0; s_we = '0; s_lock = '0; s_addr = '0; s_wdata = '0;
        clear_sb();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        // Requests during reset must not be accepted
        drive(2'b11, 2'b00, 2'b00, 10'h004, 10'h004, 32'h0, 32'h0, 2'b00, 32'h0);
        drive(2'b11, 2'b00, 2'b00, 10'h004, 10'h004, 32'h0, 32'h0, 2'b00, 32'h0);
        @(posedge clk); #1; s_valid = 2'b00; rst_n = 1'b1;

        // Single read after reset
        drive(2'b01, 2'b00, 2'b00, 10'h004, 10'h000, 32'h0, 32'h0, 2'b01, 32'hDEAD_BEEF);
        idle(1);

        // Both requesters reading every cycle
        drive(2'b11, 2'b00, 2'b00, 10'h010, 10'h020, 32'h0, 32'h0,
              c_RR ? 2'b10 : 2'b01, c_RR ? 32'hC0DE_0020 : 32'hC0DE_0010);
        drive(2'b11, 2'b00, 2'b00, 10'h010, 10'h020, 32'h0, 32'h0, 2'b01, 32'hC0DE_0010);
        drive(2'b11, 2'b00, 2'b00, 10'h010, 10'h020, 32'h0, 32'h0,
              c_RR ? 2'b10 : 2'b01, c_RR ? 32'hC0DE_0020 : 32'hC0DE_0010);
        drive(2'b11, 2'b00, 2'b00, 10'h010, 10'h020, 32'h0, 32'h0, 2'b01, 32'hC0DE_0010);
        idle(1);

        // Write by requester 0, then read of the same address by requester 1
        drive(2'b01, 2'b01, 2'b00, 10'h008, 10'h000, 32'h0000_1234, 32'h0, 2'b01, 32'h0);
        drive(2'b10, 2'b00, 2'b00, 10'h000, 10'h008, 32'h0, 32'h0, 2'b10, 32'h0000_1234);
        idle(1);

        // Locked burst of 4 reads; requester 1 waits
        drive(2'b11, 2'b00, 2'b01, 10'h030, 10'h040, 32'h0, 32'h0, 2'b01, 32'hC0DE_0030);
        drive(2'b11, 2'b00, 2'b01, 10'h031, 10'h040, 32'h0, 32'h0, 2'b01, 32'hC0DE_0031);
        drive(2'b11, 2'b00, 2'b01, 10'h032, 10'h040, 32'h0, 32'h0, 2'b01, 32'hC0DE_0032);
        drive(2'b11, 2'b00, 2'b00, 10'h033, 10'h040, 32'h0, 32'h0, 2'b01, 32'hC0DE_0033);
        drive(2'b10, 2'b00, 2'b00, 10'h033, 10'h040, 32'h0, 32'h0, 2'b10, 32'hC0DE_0040);
        idle(1);

        // Lock held indefinitely: forced release after 4 owned cycles
        drive(2'b11, 2'b00, 2'b01, 10'h050, 10'h060, 32'h0, 32'h0, 2'b01, 32'hC0DE_0050);
        drive(2'b11, 2'b00, 2'b01, 10'h050, 10'h060, 32'h0, 32'h0, 2'b01, 32'hC0DE_0050);
        drive(2'b10, 2'b00, 2'b01, 10'h050, 10'h060, 32'h0, 32'h0, 2'b00, 32'h0);
        drive(2'b11, 2'b00, 2'b01, 10'h050, 10'h060, 32'h0, 32'h0, 2'b01, 32'hC0DE_0050);
        drive(2'b11, 2'b00, 2'b01, 10'h050, 10'h060, 32'h0, 32'h0, 2'b01, 32'hC0DE_0050);
        drive(2'b11, 2'b00, 2'b01, 10'h050, 10'h060, 32'h0, 32'h0, 2'b10, 32'hC0DE_0060);
        drive(2'b11, 2'b00, 2'b01, 10'h050, 10'h060, 32'h0, 32'h0, 2'b01, 32'hC0DE_0050);
        drive(2'b11, 2'b00, 2'b00, 10'h050, 10'h060, 32'h0, 32'h0, 2'b01, 32'hC0DE_0050);
        idle(1);

        // Two reads in flight, then reset: their responses must never appear
        drive(2'b01, 2'b00, 2'b00, 10'h070, 10'h000, 32'h0, 32'h0, 2'b01, 32'hC0DE_0070);
        drive(2'b10, 2'b00, 2'b00, 10'h000, 10'h071, 32'h0, 32'h0, 2'b10, 32'hC0DE_0071);
        @(posedge clk); #1;
        rst_n = 1'b0;
        clear_sb();
        s_valid = 2'b11; s_we = 2'b00; s_lock = 2'b00;
        s_addr[0] = 10'h004; s_addr[1] = 10'h004;
        drive(2'b11, 2'b00, 2'b00, 10'h004, 10'h004, 32'h0, 32'h0, 2'b00, 32'h0);
        drive(2'b11, 2'b00, 2'b00, 10'h004, 10'h004, 32'h0, 32'h0, 2'b00, 32'h0);
        @(posedge clk); #1; s_valid = 2'b00; rst_n = 1'b1;
        idle(4);

        // Normal operation after reset, priority back to requester 0
        drive(2'b10, 2'b00, 2'b00, 10'h000, 10'h004, 32'h0, 32'h0, 2'b10, 32'hDEAD_BEEF);
        drive(2'b11, 2'b00, 2'b00, 10'h010, 10'h020, 32'h0, 32'h0, 2'b01, 32'hC0DE_0010);
        idle(4);

        n_chk++;
        if ((q_a.size() + q_b.size()) != 0) begin
            n_fail++;
            $display("FAIL pending_rsp: got %0d outstanding want 0", q_a.size() + q_b.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
